conv_window_mac: RTL

Consumes anchor coordinates from the 2D conv anchor generator and computes one convolution output per anchor. For each anchor it reads the KERNAL_HEIGHT×KERNAL_WIDTH input window from the feature-map RAM and the matching weights from the weight ROM, then multiply-accumulates them. Results go to the pooling stage over a valid/ready handshake. The anchor generator's `pause` input is driven from `!anchor_ready`.

---
 rtl/conv_pkg.sv | 26 ++
 rtl/conv_kernel_counter.sv | 42 ++++
 rtl/conv_window_mac.sv | 121 ++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared geometry defaults, FSM state encoding and address widths for the conv window MAC
package conv_pkg;

   localparam int DEF_DATA_HEIGHT   = 35;
   localparam int DEF_DATA_WIDTH    = 35;
   localparam int DEF_KERNAL_HEIGHT = 5;
   localparam int DEF_KERNAL_WIDTH  = 5;
   localparam int DEF_DATA_BITS     = 16;
   localparam int DEF_ACC_BITS      = 40;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN,
      OUT
   } conv_state_t;

   // never returns 0 so degenerate 1-wide geometries still get a legal vector
   function automatic int bits_for(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int PIX_ADDR_BITS = bits_for(DEF_DATA_HEIGHT * DEF_DATA_WIDTH);
   localparam int W_ADDR_BITS   = bits_for(DEF_KERNAL_HEIGHT * DEF_KERNAL_WIDTH);

endpackage

// File: rtl/conv_kernel_counter.sv
// rtl/conv_kernel_counter.sv - row-major kernel row/column scan counter
module conv_kernel_counter
   import conv_pkg::*;
#(
   parameter int KERNAL_HEIGHT = DEF_KERNAL_HEIGHT,
   parameter int KERNAL_WIDTH  = DEF_KERNAL_WIDTH
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   input  logic                                 advance,
   output logic [bits_for(KERNAL_HEIGHT)-1:0]   kr,
   output logic [bits_for(KERNAL_WIDTH)-1:0]    kc,
   output logic                                 last
);

   localparam int KR_BITS = bits_for(KERNAL_HEIGHT);
   localparam int KC_BITS = bits_for(KERNAL_WIDTH);

   logic kc_last;

   assign kc_last = (kc == KC_BITS'(KERNAL_WIDTH - 1));
   assign last    = kc_last && (kr == KR_BITS'(KERNAL_HEIGHT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kr <= '0;
         kc <= '0;
      end else if (start) begin
         kr <= '0;
         kc <= '0;
      end else if (advance) begin
         if (kc_last) begin
            kc <= '0;
            kr <= last ? '0 : kr + KR_BITS'(1);
         end else begin
            kc <= kc + KC_BITS'(1);
         end
      end
   end

endmodule

// File: rtl/conv_window_mac.sv
// rtl/conv_window_mac.sv - per-anchor KxK window multiply-accumulate; CONV_RELU_EN clamps negative sums to 0
module conv_window_mac
   import conv_pkg::*;
#(
   parameter int DATA_HEIGHT   = DEF_DATA_HEIGHT,
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int KERNAL_HEIGHT = DEF_KERNAL_HEIGHT,
   parameter int KERNAL_WIDTH  = DEF_KERNAL_WIDTH,
   parameter int DATA_BITS     = DEF_DATA_BITS,
   parameter int ACC_BITS      = DEF_ACC_BITS
) (
   input  logic                                                clk,
   input  logic                                                rst_n,
   input  logic                                                enable,
   input  logic                                                anchor_valid,
   output logic                                                anchor_ready,
   input  logic [31:0]                                         anchor_height,
   input  logic [31:0]                                         anchor_width,
   output logic                                                anchor_err,
   output logic                                                pix_rd_en,
   output logic [bits_for(DATA_HEIGHT*DATA_WIDTH)-1:0]         pix_rd_addr,
   input  logic signed [DATA_BITS-1:0]                         pix_rd_data,
   output logic [bits_for(KERNAL_HEIGHT*KERNAL_WIDTH)-1:0]     w_rd_addr,
   input  logic signed [DATA_BITS-1:0]                         w_rd_data,
   output logic                                                out_valid,
   input  logic                                                out_ready,
   output logic signed [ACC_BITS-1:0]                          out_data
);

   localparam int PA_BITS   = bits_for(DATA_HEIGHT * DATA_WIDTH);
   localparam int WA_BITS   = bits_for(KERNAL_HEIGHT * KERNAL_WIDTH);
   localparam int KR_BITS   = bits_for(KERNAL_HEIGHT);
   localparam int KC_BITS   = bits_for(KERNAL_WIDTH);
   localparam int PROD_BITS = 2 * DATA_BITS;

   conv_state_t                 state, state_nxt;
   logic [31:0]                 anc_h, anc_w;
   logic [KR_BITS-1:0]          kr;
   logic [KC_BITS-1:0]          kc;
   logic                        k_last;
   logic                        accept, in_range, start_ok, rd_vld;
   logic signed [PROD_BITS-1:0] prod;
   logic signed [ACC_BITS-1:0]  acc;

   // gated by rst_n so the handshake is closed for the whole reset window
   assign anchor_ready = rst_n && enable && (state == IDLE);
   assign accept       = anchor_valid && anchor_ready;
   assign in_range     = (anchor_height <= 32'(DATA_HEIGHT - KERNAL_HEIGHT)) &&
                         (anchor_width  <= 32'(DATA_WIDTH  - KERNAL_WIDTH));
   assign start_ok     = accept && in_range;

   conv_kernel_counter #(
      .KERNAL_HEIGHT (KERNAL_HEIGHT),
      .KERNAL_WIDTH  (KERNAL_WIDTH)
   ) u_kernel_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start_ok || !enable),
      .advance (state == FETCH),
      .kr      (kr),
      .kc      (kc),
      .last    (k_last)
   );

   assign pix_rd_addr = PA_BITS'((anc_h + 32'(kr)) * 32'(DATA_WIDTH) + anc_w + 32'(kc));
   assign w_rd_addr   = WA_BITS'(32'(kr) * 32'(KERNAL_WIDTH) + 32'(kc));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pix_rd_en = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE:  if (start_ok) state_nxt = FETCH;
         FETCH: begin
            pix_rd_en = 1'b1;
            if (k_last) state_nxt = DRAIN;
         end
         DRAIN: state_nxt = OUT;
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (!enable) state_nxt = IDLE;
   end

   assign prod = pix_rd_data * w_rd_data;

   // rd_vld marks the cycle the RAM/ROM pair for the previous strobe is on the bus
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         anc_h      <= '0;
         anc_w      <= '0;
         anchor_err <= 1'b0;
         rd_vld     <= 1'b0;
         acc        <= '0;
      end else begin
         anchor_err <= accept && !in_range;
         rd_vld     <= enable && pix_rd_en;
         if (start_ok) begin
            anc_h <= anchor_height;
            anc_w <= anchor_width;
         end
         if (!enable || start_ok) acc <= '0;
         else if (rd_vld)         acc <= acc + ACC_BITS'(prod);
      end
   end

`ifdef CONV_RELU_EN
   assign out_data = acc[ACC_BITS-1] ? '0 : acc;
`else
   assign out_data = acc;
`endif

endmodule
